// File: rtl/timer_apb_pkg.sv
// Shared definitions for the APB command arbiter: FSM encoding, bus widths
// and the value driven on idle data/address lines.
package timer_apb_pkg;

    localparam int APB_AW = 8;
    localparam int APB_DW = 8;

    localparam logic [APB_DW-1:0] RST_DATA = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at i_ptr and
// returns the first hit as both a one-hot grant and a binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    input  logic                       i_en,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic          w_found;
    logic [IW-1:0] w_j;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value held, which would otherwise infer a latch.
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_en && !w_found && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin arbitration, SETUP /
// ACCESS sequencing, wait-state timeout and response return to the winner.
module apb_cmd_arbiter
    import timer_apb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        cpu_clk,
    input  logic                        cpu_reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [APB_AW*NUM_REQ-1:0]   req_addr,
    input  logic [APB_DW*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [APB_DW-1:0]           rsp_rdata,
    output logic                        rsp_slverr,
    output logic                        timeout_evt,
    output logic                        cpu_sel,
    output logic                        cpu_write,
    output logic                        cpu_enable,
    output logic [APB_AW-1:0]           cpu_address,
    output logic [APB_DW-1:0]           cpu_wdata,
    input  logic [APB_DW-1:0]           cpu_rdata,
    input  logic                        cpu_ready,
    input  logic                        cpu_slverr
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam int            CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    apb_state_e   r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_owner;
    logic [CW-1:0] r_cnt;

    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic [NUM_REQ-1:0] w_owner_hot;
    logic [APB_AW-1:0]  w_addr;
    logic [APB_DW-1:0]  w_wdata;
    logic               w_write;
    logic               w_done;

    // The IDLE cycle carrying a response is skipped for arbitration, giving
    // the one-cycle gap between back-to-back transfers.
    assign w_arb_en    = !cpu_reset && (r_state == ST_IDLE) && (rsp_valid == '0);
    assign req_ack     = w_grant;
    assign w_owner_hot = NUM_REQ'(1) << r_owner;
    assign w_done      = cpu_ready || (r_cnt == CNT_LAST);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_addr  = req_addr[i*APB_AW +: APB_AW];
                w_wdata = req_wdata[i*APB_DW +: APB_DW];
                w_write = req_write[i];
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        // NOTE: all state here is updated with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (cpu_reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= RST_DATA;
            rsp_slverr  <= 1'b0;
            timeout_evt <= 1'b0;
            cpu_sel     <= 1'b0;
            cpu_write   <= 1'b0;
            cpu_enable  <= 1'b0;
            cpu_address <= RST_DATA;
            cpu_wdata   <= RST_DATA;
        end else begin
            rsp_valid   <= '0;
            rsp_rdata   <= RST_DATA;
            rsp_slverr  <= 1'b0;
            timeout_evt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != '0) begin
                        r_owner     <= w_idx;
                        cpu_sel     <= 1'b1;
                        cpu_enable  <= 1'b0;
                        cpu_write   <= w_write;
                        cpu_address <= w_addr;
                        cpu_wdata   <= w_write ? w_wdata : RST_DATA;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cpu_enable <= 1'b1;
                    r_state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        // A ready slave always wins over a coincident timeout.
                        rsp_valid   <= w_owner_hot;
                        rsp_rdata   <= (cpu_ready && !cpu_write) ? cpu_rdata : RST_DATA;
                        rsp_slverr  <= cpu_ready ? cpu_slverr : 1'b1;
                        timeout_evt <= !cpu_ready;
                        cpu_sel     <= 1'b0;
                        cpu_enable  <= 1'b0;
                        cpu_write   <= 1'b0;
                        cpu_address <= RST_DATA;
                        cpu_wdata   <= RST_DATA;
                        r_cnt       <= '0;
                        r_ptr       <= (r_owner == IDX_LAST) ? '0 : r_owner + IW'(1);
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Self-checking bench for apb_cmd_arbiter: table of single transfers with a
// response scoreboard, plus round-robin and reset-abort sequences.
module tb_apb_cmd_arbiter;

    localparam int NREQ = 2;
    localparam int TOUT = 16;

    logic              cpu_clk;
    logic              cpu_reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [8*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_slverr;
    logic              timeout_evt;
    logic              cpu_sel;
    logic              cpu_write;
    logic              cpu_enable;
    logic [7:0]        cpu_address;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ready;
    logic              cpu_slverr;

    apb_cmd_arbiter #(
        .NUM_REQ     (NREQ),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .cpu_clk     (cpu_clk),
        .cpu_reset   (cpu_reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .timeout_evt (timeout_evt),
        .cpu_sel     (cpu_sel),
        .cpu_write   (cpu_write),
        .cpu_enable  (cpu_enable),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .cpu_slverr  (cpu_slverr)
    );

    typedef struct {
        int         id;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         ws;       // ACCESS cycles with ready low before ready
        logic [7:0] s_rdata;
        logic       s_err;
        logic [7:0] e_rdata;
        logic       e_err;
        logic       e_tevt;
    } vec_t;

    typedef struct {
        int         id;
        int         cyc;
        logic [7:0] rdata;
        logic       serr;
        logic       tevt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    exp_t m_e;
    vec_t tbl[8];

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge cpu_clk) begin
        if (!cpu_reset) begin
            if (rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    m_e = sb_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(1 << m_e.id));
                    check("rsp_cycle", cyc, m_e.cyc);
                    check("rsp_rdata", 32'(rsp_rdata), 32'(m_e.rdata));
                    check("rsp_slverr", 32'(rsp_slverr), 32'(m_e.serr));
                    check("timeout_evt", 32'(timeout_evt), 32'(m_e.tevt));
                    check("bus_idle_at_rsp", 32'({cpu_sel, cpu_enable}), 32'h0);
                end
            end else begin
                check("rsp_quiet", 32'({timeout_evt, rsp_slverr, rsp_rdata}), 32'h0);
            end
        end
    end

    task automatic push_exp(input int id, input int at, input logic [7:0] rd,
                            input logic se, input logic te);
        exp_t e;
        e.id = id; e.cyc = at; e.rdata = rd; e.serr = se; e.tevt = te;
        sb_q.push_back(e);
    endtask

    task automatic run_txn(input vec_t v);
        int k;
        int en_cnt;
        int exp_en;
        @(negedge cpu_clk);
        req_write[v.id]           = v.wr;
        req_addr[v.id*8 +: 8]     = v.addr;
        req_wdata[v.id*8 +: 8]    = v.wdata;
        req_valid[v.id]           = 1'b1;
        k = 0;
        #1;
        while (req_ack == '0 && k < 20) begin
            @(negedge cpu_clk);
            #1;
            k++;
        end
        check("ack", 32'(req_ack), 32'(1 << v.id));
        if (v.ws >= TOUT) push_exp(v.id, cyc + 2 + TOUT, v.e_rdata, v.e_err, v.e_tevt);
        else              push_exp(v.id, cyc + 3 + v.ws, v.e_rdata, v.e_err, v.e_tevt);
        exp_en = (v.ws >= TOUT) ? TOUT : v.ws + 1;
        @(negedge cpu_clk);
        req_valid[v.id] = 1'b0;
        check("setup_ctl", 32'({cpu_sel, cpu_enable, cpu_write}), 32'({2'b10, v.wr}));
        check("setup_addr", 32'(cpu_address), 32'(v.addr));
        check("setup_wdata", 32'(cpu_wdata), 32'(v.wr ? v.wdata : 8'h00));
        // Slave handshake during SETUP must be ignored.
        cpu_ready  = 1'b1;
        cpu_slverr = 1'b1;
        k      = 0;
        en_cnt = 0;
        @(negedge cpu_clk);
        while (cpu_enable && k < 40) begin
            en_cnt++;
            cpu_ready  = (k == v.ws);
            cpu_rdata  = v.s_rdata;
            cpu_slverr = v.s_err;
            k++;
            @(negedge cpu_clk);
        end
        cpu_ready  = 1'b0;
        cpu_slverr = 1'b0;
        check("enable_cycles", en_cnt, exp_en);
    endtask

    // Reads with ready held high; expects alternating grants 4 cycles apart.
    task automatic collect(input int ngrant, input int first_id);
        int n;
        int k;
        int last;
        int id;
        n = 0; k = 0; last = 0;
        while (n < ngrant && k < 40) begin
            #1;
            if (n > 0 && cyc == last + 1)
                check("rr_setup_addr", 32'(cpu_address), 32'((first_id + n - 1) % 2));
            if (req_ack != '0) begin
                id = (first_id + n) % 2;
                check("rr_grant", 32'(req_ack), 32'(1 << id));
                if (n > 0) check("rr_spacing", cyc - last, 4);
                push_exp(id, cyc + 3, 8'hC3, 1'b0, 1'b0);
                last = cyc;
                n++;
            end
            @(negedge cpu_clk);
            k++;
        end
        check("rr_count", n, ngrant);
        req_valid = '0;
    endtask

    task automatic drain();
        repeat (8) @(negedge cpu_clk);
        check("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{0, 1'b1, 8'h04, 8'hA5, 0,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1, 1'b0, 8'h08, 8'hEE, 2,  8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[2] = '{0, 1'b0, 8'h10, 8'h00, 0,  8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0};
        tbl[3] = '{1, 1'b1, 8'h20, 8'h77, 1,  8'h99, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{0, 1'b0, 8'hFF, 8'h00, 0,  8'h12, 1'b1, 8'h12, 1'b1, 1'b0};
        tbl[5] = '{1, 1'b0, 8'h30, 8'h00, 16, 8'h66, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{0, 1'b0, 8'h40, 8'h00, 15, 8'h44, 1'b0, 8'h44, 1'b0, 1'b0};
        tbl[7] = '{1, 1'b1, 8'h50, 8'hC1, 14, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        cpu_reset  = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        cpu_rdata  = 8'h00;
        cpu_ready  = 1'b0;
        cpu_slverr = 1'b0;
        repeat (2) @(negedge cpu_clk);
        check("reset_bus", 32'({cpu_sel, cpu_enable, cpu_write, cpu_address, cpu_wdata}), 32'h0);
        check("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_slverr, timeout_evt, req_ack}), 32'h0);
        cpu_reset = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(tbl[i]);
        drain();

        // Both requesters held valid straight out of reset.
        @(negedge cpu_clk);
        cpu_reset  = 1'b1;
        cpu_ready  = 1'b1;
        cpu_rdata  = 8'hC3;
        req_write  = '0;
        req_addr   = {8'h01, 8'h00};
        req_valid  = 2'b11;
        #1;
        check("ack_in_reset", 32'(req_ack), 32'h0);
        @(negedge cpu_clk);
        cpu_reset = 1'b0;
        collect(4, 0);
        drain();

        // R0 transfer leaves the pointer at R1; reset mid-ACCESS must clear it.
        run_txn('{0, 1'b0, 8'h60, 8'h00, 0, 8'h21, 1'b0, 8'h21, 1'b0, 1'b0});
        drain();
        @(negedge cpu_clk);
        cpu_ready          = 1'b0;
        req_write[1]       = 1'b0;
        req_addr[15:8]     = 8'h70;
        req_valid          = 2'b10;
        #1;
        check("abort_ack", 32'(req_ack), 32'h2);
        @(negedge cpu_clk);
        req_valid = '0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        check("abort_in_access", 32'({cpu_sel, cpu_enable}), 32'h3);
        cpu_reset = 1'b1;
        @(negedge cpu_clk);
        check("abort_bus", 32'({cpu_sel, cpu_enable, cpu_write, cpu_address, cpu_wdata}), 32'h0);
        check("abort_rsp", 32'({rsp_valid, rsp_rdata, rsp_slverr, timeout_evt}), 32'h0);
        cpu_reset = 1'b0;
        cpu_ready = 1'b1;
        cpu_rdata = 8'hC3;
        req_addr  = {8'h01, 8'h00};
        req_valid = 2'b11;
        collect(2, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
